// File: rtl/word_gen_rd.sv
// Word serializer: pulls one word from a generator and emits it as a byte record,
// followed by a 3-byte packet trailer when the word closes a configuration.
module word_gen_rd #(
    parameter int CHAR_BITS    = 7,
    parameter int WORD_MAX_LEN = 8
) (
    input  logic                              CLK,
    input  logic                              rst,
    input  logic                              empty,
    output logic                              rd_en,
    input  logic [WORD_MAX_LEN*CHAR_BITS-1:0] word_in,
    input  logic [15:0]                       pkt_id,
    input  logic [15:0]                       word_id,
    input  logic [31:0]                       gen_id,
    input  logic                              gen_end,
    input  logic                              full,
    output logic                              wr_en,
    output logic [7:0]                        dout,
    output logic [31:0]                       words_sent,
    output logic                              busy
);
    localparam int REC_LEN = WORD_MAX_LEN + 6;
    localparam int IDX_W   = $clog2(REC_LEN);
    localparam int WORD_W  = WORD_MAX_LEN * CHAR_BITS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WORD    = 2'd1;
    localparam logic [1:0] ST_TRAILER = 2'd2;

    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(REC_LEN - 1);
    localparam logic [IDX_W-1:0] TRL_LAST  = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [1:0]           state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [WORD_W-1:0]    word_r;
    logic [15:0]          word_id_r;
    logic [15:0]          pkt_id_r;
    logic [31:0]          gen_id_r;
    logic                 gen_end_r;
    logic [REC_LEN*8-1:0] rec_s;
    logic [7:0]           byte_s;
    logic                 active_s;

    function automatic logic [7:0] char_to_byte(input logic [CHAR_BITS-1:0] ch);
        logic [7:0] b;
        b = 8'h00;
        b[CHAR_BITS-1:0] = ch;
        return b;
    endfunction

    assign active_s = (state_r == ST_WORD) || (state_r == ST_TRAILER);
    assign rd_en    = (state_r == ST_IDLE) & ~empty & ~rst;
    assign wr_en    = active_s & ~full & ~rst;
    assign busy     = active_s & ~rst;

    // Flatten the latched word into its byte record: chars, word_id, gen_id.
    always_comb begin
        rec_s = '0;
        for (int i = 0; i < WORD_MAX_LEN; i++) begin
            rec_s[i*8 +: 8] = char_to_byte(word_r[i*CHAR_BITS +: CHAR_BITS]);
        end
        rec_s[WORD_MAX_LEN*8 +: 16]      = word_id_r;
        rec_s[WORD_MAX_LEN*8 + 16 +: 32] = gen_id_r;
    end

    // Select the byte addressed by the current index in the active record.
    always_comb begin
        byte_s = 8'h00;
        case (state_r)
            ST_WORD: begin
                if (int'(idx_r) < REC_LEN) begin
                    byte_s = rec_s[int'(idx_r)*8 +: 8];
                end else begin
                    byte_s = 8'h00;
                end
            end
            ST_TRAILER: begin
                case (idx_r)
                    IDX_W'(0): byte_s = 8'hEE;
                    IDX_W'(1): byte_s = pkt_id_r[7:0];
                    IDX_W'(2): byte_s = pkt_id_r[15:8];
                    default:   byte_s = 8'h00;
                endcase
            end
            default: byte_s = 8'h00;
        endcase
    end

    // Reset forces the output byte to zero regardless of state.
    always_comb begin
        dout = 8'h00;
        if (rst) begin
            dout = 8'h00;
        end else begin
            dout = byte_s;
        end
    end

    // Word fields are captured only at hand-off, so later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (rst) begin
            word_r    <= '0;
            word_id_r <= 16'h0000;
            pkt_id_r  <= 16'h0000;
            gen_id_r  <= 32'h0000_0000;
            gen_end_r <= 1'b0;
        end else if (rd_en) begin
            word_r    <= word_in;
            word_id_r <= word_id;
            pkt_id_r  <= pkt_id;
            gen_id_r  <= gen_id;
            gen_end_r <= gen_end;
        end
    end

    // Record sequencing: the index only moves on bytes actually written.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            words_sent <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rd_en) begin
                        idx_r   <= '0;
                        state_r <= ST_WORD;
                    end
                end
                ST_WORD: begin
                    if (wr_en) begin
                        if (idx_r == WORD_LAST) begin
                            words_sent <= words_sent + 32'd1;
                            idx_r      <= '0;
                            state_r    <= gen_end_r ? ST_TRAILER : ST_IDLE;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (wr_en) begin
                        if (idx_r == TRL_LAST) begin
                            idx_r   <= '0;
                            state_r <= ST_IDLE;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                default: begin
                    idx_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_word_gen_rd.sv
// Directed bench for word_gen_rd: inputs change on the falling edge, outputs are
// sampled 1 time unit later, and the DUT registers on the rising edge.
module tb_word_gen_rd;
    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        empty = 1'b0;
    logic        rd_en;
    logic [55:0] word_in = 56'h0;
    logic [15:0] pkt_id = 16'h0000;
    logic [15:0] word_id = 16'h0000;
    logic [31:0] gen_id = 32'h0;
    logic        gen_end = 1'b0;
    logic        full = 1'b0;
    logic        wr_en;
    logic [7:0]  dout;
    logic [31:0] words_sent;
    logic        busy;

    int passed = 0;
    int total  = 0;
    logic [7:0] got_q[$];

    logic [7:0] exp_a [14] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67,
                               8'h68, 8'h34, 8'h12, 8'h05, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_b [14] = '{8'h69, 8'h6A, 8'h6B, 8'h6C, 8'h6D, 8'h6E, 8'h6F,
                               8'h70, 8'h78, 8'h56, 8'h04, 8'h03, 8'h02, 8'h01};
    logic [7:0] exp_t [3]  = '{8'hEE, 8'hCD, 8'hAB};

    word_gen_rd #(.CHAR_BITS(7), .WORD_MAX_LEN(8)) dut (
        .CLK(CLK), .rst(rst), .empty(empty), .rd_en(rd_en), .word_in(word_in),
        .pkt_id(pkt_id), .word_id(word_id), .gen_id(gen_id), .gen_end(gen_end),
        .full(full), .wr_en(wr_en), .dout(dout), .words_sent(words_sent), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic set_word(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] c;
            c = base + 8'(i);
            word_in[i*7 +: 7] = c[6:0];
        end
    endtask

    task automatic load_a();
        set_word(8'h61); word_id = 16'h1234; gen_id = 32'h0000_0005; pkt_id = 16'hABCD;
    endtask

    task automatic load_b();
        set_word(8'h69); word_id = 16'h5678; gen_id = 32'h0102_0304; pkt_id = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1; empty = 1'b1; full = 1'b0; gen_end = 1'b0;
        @(negedge CLK); @(negedge CLK);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; empty = 1'b0; full = 1'b0;
        @(negedge CLK); #1;
        total++; if ({rd_en, wr_en, busy} !== 3'b000) $display("FAIL rst_ctrl got %b want 000", {rd_en, wr_en, busy}); else passed++;
        total++; if (dout !== 8'h00) $display("FAIL rst_dout got %h want 00", dout); else passed++;
        total++; if (words_sent !== 32'h0) $display("FAIL rst_words got %h want 0", words_sent); else passed++;
        @(negedge CLK); rst = 1'b0; #1;
        total++; if (rd_en !== 1'b1) $display("FAIL rst_first_rd got %b want 1", rd_en); else passed++;
    endtask

    task automatic test_single_word();
        do_reset(); load_a(); gen_end = 1'b0; empty = 1'b0; #1;
        total++; if (rd_en !== 1'b1) $display("FAIL s1_rd_en got %b want 1", rd_en); else passed++;
        @(negedge CLK); empty = 1'b1; load_b();
        for (int i = 0; i < 14; i++) begin
            #1;
            total++; if ({wr_en, dout} !== {1'b1, exp_a[i]}) $display("FAIL s1_byte[%0d] got %b/%h want 1/%h", i, wr_en, dout, exp_a[i]); else passed++;
            @(negedge CLK);
        end
        #1;
        total++; if ({busy, wr_en, rd_en} !== 3'b000) $display("FAIL s1_idle got %b want 000", {busy, wr_en, rd_en}); else passed++;
        total++; if (words_sent !== 32'd1) $display("FAIL s1_words got %0d want 1", words_sent); else passed++;
    endtask

    task automatic test_trailer();
        do_reset(); load_a(); gen_end = 1'b1; empty = 1'b0; #1;
        total++; if (rd_en !== 1'b1) $display("FAIL s2_rd_en got %b want 1", rd_en); else passed++;
        @(negedge CLK); empty = 1'b1; gen_end = 1'b0; pkt_id = 16'h1111;
        for (int i = 0; i < 17; i++) begin
            logic [7:0] e;
            e = (i < 14) ? exp_a[i] : exp_t[i-14];
            #1;
            total++; if ({wr_en, busy, dout} !== {2'b11, e}) $display("FAIL s2_byte[%0d] got %b%b/%h want 11/%h", i, wr_en, busy, dout, e); else passed++;
            @(negedge CLK);
        end
        #1;
        total++; if ({busy, wr_en} !== 2'b00) $display("FAIL s2_idle got %b want 00", {busy, wr_en}); else passed++;
        total++; if (words_sent !== 32'd1) $display("FAIL s2_words got %0d want 1", words_sent); else passed++;
    endtask

    task automatic test_full_stall();
        int bi;
        bi = 0;
        do_reset(); load_a(); gen_end = 1'b0; empty = 1'b0;
        @(negedge CLK); empty = 1'b1;
        for (int c = 0; c < 17; c++) begin
            full = (c >= 5 && c < 8);
            #1;
            if (full) begin
                total++; if ({wr_en, dout} !== {1'b0, exp_a[5]}) $display("FAIL s3_hold[%0d] got %b/%h want 0/%h", c, wr_en, dout, exp_a[5]); else passed++;
            end else begin
                total++; if ({wr_en, dout} !== {1'b1, exp_a[bi]}) $display("FAIL s3_byte[%0d] got %b/%h want 1/%h", bi, wr_en, dout, exp_a[bi]); else passed++;
                bi++;
            end
            @(negedge CLK);
        end
        full = 1'b0; #1;
        total++; if (busy !== 1'b0) $display("FAIL s3_done got busy=%b want 0", busy); else passed++;
        total++; if (words_sent !== 32'd1) $display("FAIL s3_words got %0d want 1", words_sent); else passed++;
    endtask

    task automatic test_full_last();
        do_reset(); load_a(); gen_end = 1'b0; empty = 1'b0;
        @(negedge CLK); empty = 1'b1;
        repeat (13) @(negedge CLK);
        full = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if ({wr_en, busy} !== 2'b01) $display("FAIL last_hold[%0d] got %b want 01", c, {wr_en, busy}); else passed++;
            total++; if (words_sent !== 32'd0) $display("FAIL last_words[%0d] got %0d want 0", c, words_sent); else passed++;
            @(negedge CLK);
        end
        full = 1'b0; #1;
        total++; if ({wr_en, dout} !== {1'b1, 8'h00}) $display("FAIL last_write got %b/%h want 1/00", wr_en, dout); else passed++;
        @(negedge CLK); #1;
        total++; if ({busy, words_sent} !== {1'b0, 32'd1}) $display("FAIL last_after got %b/%0d want 0/1", busy, words_sent); else passed++;
    endtask

    task automatic test_back_to_back();
        int p0;
        int p1;
        p0 = -1; p1 = -1;
        got_q.delete();
        do_reset(); load_a(); gen_end = 1'b0; empty = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 3) load_b();
            #1;
            if (rd_en) begin
                if (p0 < 0) p0 = c;
                else if (p1 < 0) p1 = c;
            end
            if (wr_en) got_q.push_back(dout);
            @(negedge CLK);
        end
        empty = 1'b1; #1;
        total++; if (p0 !== 0) $display("FAIL b2b_first_rd got %0d want 0", p0); else passed++;
        total++; if (p1 - p0 !== 15) $display("FAIL b2b_period got %0d want 15", p1 - p0); else passed++;
        total++; if (got_q.size() !== 28) $display("FAIL b2b_count got %0d want 28", got_q.size()); else passed++;
        if (got_q.size() == 28) begin
            for (int i = 0; i < 28; i++) begin
                logic [7:0] e;
                e = (i < 14) ? exp_a[i] : exp_b[i-14];
                total++; if (got_q[i] !== e) $display("FAIL b2b_byte[%0d] got %h want %h", i, got_q[i], e); else passed++;
            end
        end
        total++; if (words_sent !== 32'd2) $display("FAIL b2b_words got %0d want 2", words_sent); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset(); load_a(); gen_end = 1'b0; empty = 1'b0;
        @(negedge CLK); empty = 1'b1;
        repeat (9) @(negedge CLK);
        #1;
        total++; if ({wr_en, dout} !== {1'b1, 8'h12}) $display("FAIL s5_idx9 got %b/%h want 1/12", wr_en, dout); else passed++;
        @(negedge CLK);
        rst = 1'b1; empty = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if ({wr_en, rd_en, busy, dout} !== 11'h000) $display("FAIL s5_in_rst[%0d] got %b%b%b/%h want 000/00", c, wr_en, rd_en, busy, dout); else passed++;
            total++; if (words_sent !== 32'd0) $display("FAIL s5_rst_words[%0d] got %0d want 0", c, words_sent); else passed++;
            @(negedge CLK);
        end
        rst = 1'b0; empty = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if ({wr_en, busy} !== 2'b00) $display("FAIL s5_after[%0d] got %b want 00", c, {wr_en, busy}); else passed++;
            @(negedge CLK);
        end
        load_b(); empty = 1'b0; #1;
        total++; if (rd_en !== 1'b1) $display("FAIL s5_new_rd got %b want 1", rd_en); else passed++;
        @(negedge CLK); empty = 1'b1;
        for (int i = 0; i < 14; i++) begin
            #1;
            total++; if ({wr_en, dout} !== {1'b1, exp_b[i]}) $display("FAIL s5_byte[%0d] got %b/%h want 1/%h", i, wr_en, dout, exp_b[i]); else passed++;
            @(negedge CLK);
        end
        #1;
        total++; if (words_sent !== 32'd1) $display("FAIL s5_words got %0d want 1", words_sent); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.words_sent = 32'hFFFF_FFFF;
        @(negedge CLK);
        release dut.words_sent;
        #1;
        total++; if (words_sent !== 32'hFFFF_FFFF) $display("FAIL wrap_preset got %h want ffffffff", words_sent); else passed++;
        load_a(); gen_end = 1'b0; empty = 1'b0;
        @(negedge CLK); empty = 1'b1;
        repeat (14) @(negedge CLK);
        #1;
        total++; if ({busy, words_sent} !== {1'b0, 32'h0}) $display("FAIL wrap_zero got %b/%h want 0/00000000", busy, words_sent); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_trailer();
        test_full_stall();
        test_full_last();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
